// File: rtl/mask_calib_ctrl_pkg.sv
// Shared types and reset constants for the colour-mask configuration path.
// Also used by the two_color_mask instantiation so both sides agree on defaults.
package mask_calib_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      ACCUM,
      AVG,
      PEND
   } cal_state_t;

   localparam int YUV_WIDTH    = 9;
   localparam int THRESH_WIDTH = 7;

   localparam int DEF_U1  = -26;
   localparam int DEF_V1  = 0;
   localparam int DEF_U2  = 0;
   localparam int DEF_V2  = 1;
   localparam int DEF_THR = 5;

endpackage

// File: rtl/mask_calib_ctrl_pixel_pos_counter.sv
// Raster position tracker: row/col of the next accepted pixel and a frame-end
// strobe that is high while the last pixel of the frame is being presented.
module pixel_pos_counter #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int CW     = $clog2(WIDTH),
   parameter int RW     = $clog2(HEIGHT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_valid,
   output logic [RW-1:0] o_row,
   output logic [CW-1:0] o_col,
   output logic          o_fe
);

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic          w_lastCol;
   logic          w_lastRow;

   assign w_lastCol = (r_col == CW'(WIDTH - 1));
   assign w_lastRow = (r_row == RW'(HEIGHT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_valid) begin
         if (w_lastCol) begin
            r_col <= '0;
            r_row <= w_lastRow ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row = r_row;
   assign o_col = r_col;
   assign o_fe  = i_valid & w_lastRow & w_lastCol;

endmodule

// File: rtl/mask_calib_ctrl.sv
// Owns the active colour targets/thresholds for two_color_mask and calibrates one
// target from a centred WIN x WIN window; every change lands on a frame boundary.
module mask_calib_ctrl #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int YUV_WIDTH    = mask_calib_ctrl_pkg::YUV_WIDTH,
   parameter int THRESH_WIDTH = mask_calib_ctrl_pkg::THRESH_WIDTH,
   parameter int WIN          = 16,
   parameter int DEF_U1       = mask_calib_ctrl_pkg::DEF_U1,
   parameter int DEF_V1       = mask_calib_ctrl_pkg::DEF_V1,
   parameter int DEF_U2       = mask_calib_ctrl_pkg::DEF_U2,
   parameter int DEF_V2       = mask_calib_ctrl_pkg::DEF_V2,
   parameter int DEF_THR      = mask_calib_ctrl_pkg::DEF_THR
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic signed [YUV_WIDTH-1:0]    U,
   input  logic signed [YUV_WIDTH-1:0]    V,
   input  logic                           cal_start,
   input  logic                           cal_sel,
   input  logic                           cal_abort,
   input  logic        [THRESH_WIDTH-1:0] thr_u1,
   input  logic        [THRESH_WIDTH-1:0] thr_v1,
   input  logic        [THRESH_WIDTH-1:0] thr_u2,
   input  logic        [THRESH_WIDTH-1:0] thr_v2,
   output logic signed [YUV_WIDTH-1:0]    uTarget1,
   output logic signed [YUV_WIDTH-1:0]    vTarget1,
   output logic signed [YUV_WIDTH-1:0]    uTarget2,
   output logic signed [YUV_WIDTH-1:0]    vTarget2,
   output logic        [THRESH_WIDTH-1:0] uThresh1,
   output logic        [THRESH_WIDTH-1:0] vThresh1,
   output logic        [THRESH_WIDTH-1:0] uThresh2,
   output logic        [THRESH_WIDTH-1:0] vThresh2,
   output logic                           cal_busy,
   output logic                           cal_done,
   output logic                           frame_done
);

   import mask_calib_ctrl_pkg::*;

   localparam int CW     = $clog2(WIDTH);
   localparam int RW     = $clog2(HEIGHT);
   localparam int SHIFT  = 2 * $clog2(WIN);
   localparam int ACC_W  = YUV_WIDTH + SHIFT;
   localparam int ROW_LO = HEIGHT / 2 - WIN / 2;
   localparam int ROW_HI = HEIGHT / 2 + WIN / 2 - 1;
   localparam int COL_LO = WIDTH / 2 - WIN / 2;
   localparam int COL_HI = WIDTH / 2 + WIN / 2 - 1;

   logic [RW-1:0] w_row;
   logic [CW-1:0] w_col;
   logic          w_fe;
   logic          w_inWin;
   logic          w_lastWinPix;

   cal_state_t r_state;
   cal_state_t w_nextState;
   logic       w_accClr;
   logic       w_accEn;
   logic       w_selLatch;
   logic       w_avgLoad;
   logic       w_tgtWr;

   logic                           r_sel;
   logic signed [ACC_W-1:0]        r_sumU;
   logic signed [ACC_W-1:0]        r_sumV;
   logic signed [YUV_WIDTH-1:0]    r_avgU;
   logic signed [YUV_WIDTH-1:0]    r_avgV;
   logic signed [YUV_WIDTH-1:0]    r_uT1;
   logic signed [YUV_WIDTH-1:0]    r_vT1;
   logic signed [YUV_WIDTH-1:0]    r_uT2;
   logic signed [YUV_WIDTH-1:0]    r_vT2;
   logic        [THRESH_WIDTH-1:0] r_uTh1;
   logic        [THRESH_WIDTH-1:0] r_vTh1;
   logic        [THRESH_WIDTH-1:0] r_uTh2;
   logic        [THRESH_WIDTH-1:0] r_vTh2;
   logic                           r_calDone;
   logic                           r_frameDone;

   pixel_pos_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_pos (
      .clk     (clk),
      .reset   (reset),
      .i_valid (in_valid),
      .o_row   (w_row),
      .o_col   (w_col),
      .o_fe    (w_fe)
   );

   assign w_inWin = (w_row >= RW'(ROW_LO)) && (w_row <= RW'(ROW_HI)) &&
                    (w_col >= CW'(COL_LO)) && (w_col <= CW'(COL_HI));
   assign w_lastWinPix = in_valid && (w_row == RW'(ROW_HI)) && (w_col == CW'(COL_HI));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Abort outranks everything outside IDLE, including a same-cycle frame end in PEND.
   always_comb begin
      w_nextState = r_state;
      w_accClr    = 1'b0;
      w_accEn     = 1'b0;
      w_selLatch  = 1'b0;
      w_avgLoad   = 1'b0;
      w_tgtWr     = 1'b0;
      if (cal_abort && (r_state != IDLE)) begin
         w_nextState = IDLE;
         w_accClr    = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (cal_start) begin
                  w_selLatch  = 1'b1;
                  w_accClr    = 1'b1;
                  w_nextState = ARM;
               end
            end
            ARM: begin
               if (w_fe) w_nextState = ACCUM;
            end
            ACCUM: begin
               w_accEn = in_valid & w_inWin;
               if (w_lastWinPix) w_nextState = AVG;
            end
            AVG: begin
               w_avgLoad   = 1'b1;
               w_nextState = PEND;
            end
            PEND: begin
               if (w_fe) begin
                  w_tgtWr     = 1'b1;
                  w_nextState = IDLE;
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Window sums are wide enough for WIN*WIN extreme samples, so the averaged value always fits YUV_WIDTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel  <= 1'b0;
         r_sumU <= '0;
         r_sumV <= '0;
         r_avgU <= '0;
         r_avgV <= '0;
      end else begin
         if (w_selLatch) r_sel <= cal_sel;
         if (w_accClr) begin
            r_sumU <= '0;
            r_sumV <= '0;
         end else if (w_accEn) begin
            r_sumU <= r_sumU + ACC_W'(U);
            r_sumV <= r_sumV + ACC_W'(V);
         end
         if (w_avgLoad) begin
            r_avgU <= YUV_WIDTH'(r_sumU >>> SHIFT);
            r_avgV <= YUV_WIDTH'(r_sumV >>> SHIFT);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_uT1       <= YUV_WIDTH'(DEF_U1);
         r_vT1       <= YUV_WIDTH'(DEF_V1);
         r_uT2       <= YUV_WIDTH'(DEF_U2);
         r_vT2       <= YUV_WIDTH'(DEF_V2);
         r_uTh1      <= THRESH_WIDTH'(DEF_THR);
         r_vTh1      <= THRESH_WIDTH'(DEF_THR);
         r_uTh2      <= THRESH_WIDTH'(DEF_THR);
         r_vTh2      <= THRESH_WIDTH'(DEF_THR);
         r_calDone   <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         if (w_tgtWr && !r_sel) begin
            r_uT1 <= r_avgU;
            r_vT1 <= r_avgV;
         end
         if (w_tgtWr && r_sel) begin
            r_uT2 <= r_avgU;
            r_vT2 <= r_avgV;
         end
         if (w_fe) begin
            r_uTh1 <= thr_u1;
            r_vTh1 <= thr_v1;
            r_uTh2 <= thr_u2;
            r_vTh2 <= thr_v2;
         end
         r_calDone   <= w_tgtWr;
         r_frameDone <= w_fe;
      end
   end

   assign uTarget1   = r_uT1;
   assign vTarget1   = r_vT1;
   assign uTarget2   = r_uT2;
   assign vTarget2   = r_vT2;
   assign uThresh1   = r_uTh1;
   assign vThresh1   = r_vTh1;
   assign uThresh2   = r_uTh2;
   assign vThresh2   = r_vTh2;
   assign cal_busy   = (r_state != IDLE);
   assign cal_done   = r_calDone;
   assign frame_done = r_frameDone;

endmodule

// File: tb/tb_mask_calib_ctrl.sv
// Directed bench for mask_calib_ctrl on a reduced 32x16 frame with an 8x8 window.
// Calibration cases come from a vector table; abort/reset/ignored-start are hand sequences.
module tb_mask_calib_ctrl;

   localparam int W     = 32;
   localparam int H     = 16;
   localparam int WN    = 8;
   localparam int YW    = 9;
   localparam int TW    = 7;
   localparam int FRAME = W * H;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic signed [YW-1:0] U;
   logic signed [YW-1:0] V;
   logic                 cal_start;
   logic                 cal_sel;
   logic                 cal_abort;
   logic        [TW-1:0] thr_u1, thr_v1, thr_u2, thr_v2;
   logic signed [YW-1:0] uTarget1, vTarget1, uTarget2, vTarget2;
   logic        [TW-1:0] uThresh1, vThresh1, uThresh2, vThresh2;
   logic                 cal_busy, cal_done, frame_done;

   mask_calib_ctrl #(
      .WIDTH  (W),
      .HEIGHT (H),
      .WIN    (WN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .U          (U),
      .V          (V),
      .cal_start  (cal_start),
      .cal_sel    (cal_sel),
      .cal_abort  (cal_abort),
      .thr_u1     (thr_u1),
      .thr_v1     (thr_v1),
      .thr_u2     (thr_u2),
      .thr_v2     (thr_v2),
      .uTarget1   (uTarget1),
      .vTarget1   (vTarget1),
      .uTarget2   (uTarget2),
      .vTarget2   (vTarget2),
      .uThresh1   (uThresh1),
      .vThresh1   (vThresh1),
      .uThresh2   (uThresh2),
      .vThresh2   (vThresh2),
      .cal_busy   (cal_busy),
      .cal_done   (cal_done),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit sel;
      bit gaps;
      int ua;
      int ub;
      int va;
      int vb;
      int expU;
      int expV;
   } calVec_t;

   calVec_t vecTab[7];

   int vecs = 0;
   int errs = 0;
   int doneSeen = 0;
   int frameSeen = 0;
   int bRow = 0;
   int bCol = 0;
   int pa, pb, pc, pd;
   bit gapsOn = 0;
   int mU[2];
   int mV[2];

   always @(posedge clk) begin
      if (cal_done) doneSeen <= doneSeen + 1;
      if (frame_done) frameSeen <= frameSeen + 1;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit inWin(input int r, input int c);
      return (r >= H/2 - WN/2) && (r <= H/2 + WN/2 - 1) &&
             (c >= W/2 - WN/2) && (c <= W/2 + WN/2 - 1);
   endfunction

   function automatic int tgtU(input int sel);
      return sel ? int'(uTarget2) : int'(uTarget1);
   endfunction

   function automatic int tgtV(input int sel);
      return sel ? int'(vTarget2) : int'(vTarget1);
   endfunction

   task automatic idleTick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendPixel(input int u, input int v);
      int k;
      k = 0;
      if (gapsOn) begin
         while (k < 6 && $urandom_range(1) == 1) begin
            idleTick();
            k++;
         end
      end
      in_valid = 1'b1;
      U = u[YW-1:0];
      V = v[YW-1:0];
      idleTick();
      in_valid = 1'b0;
      if (bCol == W - 1) begin
         bCol = 0;
         bRow = (bRow == H - 1) ? 0 : bRow + 1;
      end else begin
         bCol++;
      end
   endtask

   // Window pixels alternate by column parity; everything outside gets values the average must not see.
   task automatic applyStimulus();
      int u, v;
      if (inWin(bRow, bCol)) begin
         u = (bCol % 2 == 0) ? pa : pb;
         v = (bCol % 2 == 0) ? pc : pd;
      end else begin
         u = 77;
         v = -77;
      end
      sendPixel(u, v);
   endtask

   task automatic checkTargets(input string tag);
      checkOutput({tag, " uTarget1"}, int'(uTarget1), mU[0]);
      checkOutput({tag, " vTarget1"}, int'(vTarget1), mV[0]);
      checkOutput({tag, " uTarget2"}, int'(uTarget2), mU[1]);
      checkOutput({tag, " vTarget2"}, int'(vTarget2), mV[1]);
   endtask

   task automatic runCal(input calVec_t t);
      int pos0, expLat, cnt, d0;
      bit got;
      pos0   = bRow * W + bCol;
      expLat = 2 * FRAME - pos0;
      pa = t.ua; pb = t.ub; pc = t.va; pd = t.vb;
      gapsOn = t.gaps;
      cal_sel = t.sel;
      cal_start = 1'b1;
      idleTick();
      cal_start = 1'b0;
      checkOutput("busy after start", int'(cal_busy), 1);
      d0 = doneSeen;
      cnt = 0;
      got = 0;
      while (!got && cnt < 3 * FRAME) begin
         if (cnt == expLat - 1) checkOutput("target held before fe", tgtU(int'(t.sel)), mU[t.sel]);
         applyStimulus();
         cnt++;
         if (cal_done) got = 1;
      end
      checkOutput("cal_done latency", cnt, expLat);
      mU[t.sel] = t.expU;
      mV[t.sel] = t.expV;
      checkTargets("cal result");
      idleTick();
      checkOutput("cal_done width", int'(cal_done), 0);
      checkOutput("busy after done", int'(cal_busy), 0);
      checkOutput("cal_done count", doneSeen - d0, 1);
      gapsOn = 0;
   endtask

   task automatic alignFrame();
      int pos;
      pos = bRow * W + bCol;
      repeat ((FRAME - pos) % FRAME) applyStimulus();
   endtask

   task automatic resetModel();
      mU[0] = -26; mV[0] = 0;
      mU[1] = 0;   mV[1] = 1;
      bRow = 0;
      bCol = 0;
   endtask

   initial begin
      int d0, f0, cnt;
      bit got;

      vecTab[0] = '{0, 0, -20, -20, 3, 3, -20, 3};
      vecTab[1] = '{1, 0, -10, -11, 0, 0, -11, 0};
      vecTab[2] = '{0, 0, 255, 255, -256, -256, 255, -256};
      vecTab[3] = '{1, 0, 7, 8, -1, -2, 7, -2};
      vecTab[4] = '{0, 0, -256, 255, 100, -100, -1, 0};
      vecTab[5] = '{1, 0, 1, 0, -3, 4, 0, 0};
      vecTab[6] = '{1, 1, -20, -20, 3, 3, -20, 3};

      reset = 1'b1;
      in_valid = 1'b0;
      U = '0;
      V = '0;
      cal_start = 1'b0;
      cal_sel = 1'b0;
      cal_abort = 1'b0;
      thr_u1 = 7'd5; thr_v1 = 7'd5; thr_u2 = 7'd5; thr_v2 = 7'd5;
      pa = 0; pb = 0; pc = 0; pd = 0;
      resetModel();
      repeat (3) idleTick();
      reset = 1'b0;
      idleTick();

      $display("[TB] reset state");
      checkTargets("reset");
      checkOutput("reset uThresh1", int'(uThresh1), 5);
      checkOutput("reset vThresh2", int'(vThresh2), 5);
      checkOutput("reset cal_busy", int'(cal_busy), 0);
      checkOutput("reset cal_done", int'(cal_done), 0);
      checkOutput("reset frame_done", int'(frame_done), 0);

      $display("[TB] threshold shadowing over one frame");
      thr_u1 = 7'd9; thr_v1 = 7'd12; thr_u2 = 7'd0; thr_v2 = 7'd127;
      f0 = frameSeen;
      repeat (FRAME - 1) applyStimulus();
      checkOutput("uThresh1 before fe", int'(uThresh1), 5);
      checkOutput("frame_done before fe", int'(frame_done), 0);
      applyStimulus();
      checkOutput("uThresh1 after fe", int'(uThresh1), 9);
      checkOutput("vThresh1 after fe", int'(vThresh1), 12);
      checkOutput("uThresh2 after fe", int'(uThresh2), 0);
      checkOutput("vThresh2 after fe", int'(vThresh2), 127);
      checkOutput("frame_done at fe", int'(frame_done), 1);
      idleTick();
      checkOutput("frame_done width", int'(frame_done), 0);
      checkOutput("frame_done count", frameSeen - f0, 1);

      $display("[TB] calibration vector table");
      for (int i = 0; i < 7; i++) begin
         repeat (i * 37) applyStimulus();
         runCal(vecTab[i]);
      end

      $display("[TB] cal_start during ACCUM is ignored");
      alignFrame();
      pa = -5; pb = -5; pc = 6; pd = 6;
      cal_sel = 1'b0;
      cal_start = 1'b1;
      idleTick();
      cal_start = 1'b0;
      repeat (FRAME + 6 * W) applyStimulus();
      cal_sel = 1'b1;
      cal_start = 1'b1;
      idleTick();
      cal_start = 1'b0;
      cal_sel = 1'b0;
      cnt = 0;
      got = 0;
      while (!got && cnt < 2 * FRAME) begin
         applyStimulus();
         cnt++;
         if (cal_done) got = 1;
      end
      checkOutput("restart ignored done", int'(got), 1);
      mU[0] = -5;
      mV[0] = 6;
      checkTargets("restart ignored");

      $display("[TB] abort during ACCUM");
      alignFrame();
      pa = 50; pb = 50; pc = 50; pd = 50;
      cal_sel = 1'b1;
      cal_start = 1'b1;
      idleTick();
      cal_start = 1'b0;
      repeat (FRAME + 8 * W) applyStimulus();
      cal_abort = 1'b1;
      idleTick();
      cal_abort = 1'b0;
      checkOutput("busy after abort", int'(cal_busy), 0);
      d0 = doneSeen;
      repeat (2 * FRAME) applyStimulus();
      checkOutput("no done after abort", doneSeen - d0, 0);
      checkTargets("abort accum");

      $display("[TB] abort on frame end in PEND");
      alignFrame();
      pa = 60; pb = 60; pc = -60; pd = -60;
      cal_sel = 1'b0;
      cal_start = 1'b1;
      idleTick();
      cal_start = 1'b0;
      d0 = doneSeen;
      repeat (2 * FRAME - 1) applyStimulus();
      checkOutput("busy in PEND", int'(cal_busy), 1);
      cal_abort = 1'b1;
      applyStimulus();
      cal_abort = 1'b0;
      checkOutput("pend abort frame_done", int'(frame_done), 1);
      checkOutput("pend abort cal_done", int'(cal_done), 0);
      checkOutput("pend abort busy", int'(cal_busy), 0);
      idleTick();
      checkOutput("pend abort done count", doneSeen - d0, 0);
      checkTargets("abort pend");

      $display("[TB] reset during ACCUM");
      alignFrame();
      pa = -100; pb = -100; pc = 20; pd = 20;
      cal_sel = 1'b0;
      cal_start = 1'b1;
      idleTick();
      cal_start = 1'b0;
      repeat (FRAME + 10 * W) applyStimulus();
      #2;
      reset = 1'b1;
      #1;
      resetModel();
      checkTargets("async reset");
      checkOutput("async reset uThresh1", int'(uThresh1), 5);
      checkOutput("async reset busy", int'(cal_busy), 0);
      @(negedge clk);
      reset = 1'b0;
      idleTick();
      d0 = doneSeen;
      repeat (2 * FRAME) applyStimulus();
      checkOutput("no done after reset", doneSeen - d0, 0);
      checkTargets("post reset");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
